dma_wr_dealigner: RTL
=====================

# dma_wr_dealigner

Parametrised write-path byte dealigner for the DMA controller. It takes a packed, word-wide byte stream from the read-data FIFO and re-packs it onto bus-aligned write beats for an arbitrary unaligned start address. Each beat carries byte strobes. It supports ready/valid backpressure on both sides, any data width that is a power-of-two number of bytes, and multi-kilobyte lengths. It emits a trailing flush beat when the tail spills into an extra word. It sits between the DMA data FIFO and the AXI write-channel master.

## Interface
Parameters:
- DATA_W, 32: data width in bits; power of two, 32..128. NB = DATA_W/8, OFF_W = log2(NB).
- ADDR_W, 32: address width.
- LEN_W, 16: byte-length width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command pulse; ignored while busy.
- start_addr  in  ADDR_W  byte start address, any alignment.
- start_len  in  LEN_W  byte count; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat handshake.
- in_valid  in  1  FIFO word valid.
- in_ready  out  1  word consumed when in_valid && in_ready.
- in_data  in  DATA_W  packed stream; transfer byte 0 is in the first word at [7:0].
- out_valid  out  1  write beat valid.
- out_ready  in  1  beat accepted when out_valid && out_ready.
- out_data  out  DATA_W  aligned write data; non-strobed bytes are driven 0.
- out_strb  out  NB  byte strobes.
- out_last  out  1  final beat of the transfer.
- out_addr  out  ADDR_W  aligned beat address; present only with DEALIGN_ADDR_OUT_EN.

## Operation
- On start: latch off = start_addr[OFF_W-1:0], the aligned base, and len. Compute in_words = ceil(len/NB) and out_beats = ceil((off+len)/NB). Compute end e = (off+len) mod NB; e = 0 means the last beat is full.
- States:
  - IDLE -> RUN on start with len != 0.
  - IDLE -> DONE on start with len == 0; no beats are produced.
  - RUN -> FLUSH when the last input word is consumed and out_beats > in_words.
  - RUN -> DONE on the out_last handshake.
  - FLUSH -> DONE on the flush-beat handshake.
  - DONE -> IDLE after one cycle (done pulse).
- Byte mapping for beat k:
  - Byte j >= off comes from input word k, byte j-off.
  - Byte j < off comes from the hold register, which stores bytes NB-off..NB-1 of input word k-1.
  - Beat 0 hold bytes are strobe-0. The FLUSH beat uses the hold bytes only.
- Strobes:
  - First beat clears bits below off.
  - Last beat clears bits >= e when e != 0.
  - A single-beat transfer applies both masks.
  - Input bytes beyond len in the last word are ignored and masked.
- Counters: words_left and beats_left are LEN_W+1 bits wide and decrement on their respective handshakes. out_last is asserted when beats_left == 1.

## Timing
- Reset values: busy 0, done 0, in_ready 0, out_valid 0, out_data 0, out_strb 0, out_last 0, out_addr 0, state IDLE, hold 0.
- Start in cycle T: busy and in_ready can be high at T+1. The first out_valid is no earlier than T+2, giving 1-cycle registered latency from input handshake to output.
- Throughput: 1 beat/cycle with in_valid and out_ready held high.
- in_ready = (state == RUN) && words_left != 0 && (!out_valid || out_ready).
- out_valid, out_data, out_strb, out_last and out_addr stay stable while out_valid && !out_ready.
- The flush beat is loaded in the cycle after the last input handshake, provided the output register is free.
- done pulses one cycle after the final output handshake. busy falls in the same cycle.
- Reset mid-transfer: all state clears immediately. Pending FIFO words are not drained.

## Configuration
- DEALIGN_ADDR_OUT_EN defined: the out_addr port and a beat address register exist. out_addr is the aligned base on beat 0 and increments by NB after each output handshake.
- Not defined: the port and register are absent. The data, strobe and last behaviour is identical in both builds.

## Structure
- Package dma_dealign_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - the functions first_strb(off) and last_strb(e), both parametrised by NB.
- Sub-module dealign_shifter: purely combinational merge of hold and in_data by off into beat data. It is instantiated once.

## Test plan
All cases use DATA_W=32 unless noted.
- off0: addr 0x100, len 8, words 0x44332211 and 0x88776655 -> 2 beats with strb 1111 and identical data. out_last on beat 2, done one cycle later.
- off1: addr 0x101, len 5, words 0x44332211 and 0x00000055 -> beat 0x33221100/1110, then beat 0x00005544/0011 with last. No flush.
- off2 with flush: addr 0x102, len 7, words 0x44332211 and 0x00776655 -> beats 0x22110000/1100, 0x66554433/1111 and 0x00000077/0001 (last). Repeat with out_ready toggling 1010 and check outputs hold stable while stalled.
- off3: addr 0x103, len 1, word 0x000000AA -> one beat 0xAA000000/1000 with last.
- Zero length: len 0 -> no in_ready, no out_valid, done pulse at T+2. A start asserted while busy is ignored.
- Reset mid-transfer: assert rst after beat 1 of a 64-byte transfer -> all outputs 0 immediately. A fresh transfer then completes correctly. Rerun the off2 case with DATA_W=64 and DEALIGN_ADDR_OUT_EN defined, checking out_addr 0x100, 0x108, ...

Source files
------------

// File: rtl/dma_dealign_pkg.sv
// Shared types and strobe helpers for the DMA write-path dealigner.
package dma_dealign_pkg;

  localparam int MAX_NB = 16;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Strobes for lanes off..nb-1 (first beat of a transfer).
  function automatic logic [MAX_NB-1:0] first_strb(int off, int nb);
    logic [MAX_NB-1:0] m;
    for (int i = 0; i < MAX_NB; i++) m[i] = (i >= off) && (i < nb);
    return m;
  endfunction

  // Strobes for lanes below e; e == 0 means the final beat is full.
  function automatic logic [MAX_NB-1:0] last_strb(int e, int nb);
    logic [MAX_NB-1:0] m;
    for (int i = 0; i < MAX_NB; i++) m[i] = (i < nb) && ((e == 0) || (i < e));
    return m;
  endfunction

endpackage

// File: rtl/dma_wr_dealigner_shifter.sv
// Combinational merge of the held tail bytes and the current word into one aligned beat.
module dealign_shifter #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] hold,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] beat
);

  // hold only ever has lanes below off populated, so a plain OR merges cleanly
  assign beat = (in_data << {off, 3'b000}) | hold;

endmodule

// File: rtl/dma_wr_dealigner.sv
// Repacks a packed FIFO byte stream onto address-aligned, strobed write beats.
// Define DEALIGN_ADDR_OUT_EN to add the out_addr beat address port.
module dma_wr_dealigner
  import dma_dealign_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    start_len,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_strb,
  output logic                out_last
`ifdef DEALIGN_ADDR_OUT_EN
  ,
  output logic [ADDR_W-1:0]   out_addr
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CW    = LEN_W + 1;

  state_t            state;
  logic [OFF_W-1:0]  off, e_r, off_s;
  logic              flush_req, first_pend;
  logic [CW-1:0]     words_left, beats_left, span, in_words, out_beats;
  logic [DATA_W-1:0] hold, hold_nxt, shifted, data_raw, data_n, byte_mask;
  logic [NB-1:0]     strb_n, first_m, last_m;
  logic [OFF_W:0]    rem;
  logic              in_hs, out_hs, out_free, flush_load, load;

  assign off_s     = start_addr[OFF_W-1:0];
  assign span      = CW'(start_len) + CW'(off_s);
  assign in_words  = (CW'(start_len) + CW'(NB - 1)) >> OFF_W;
  assign out_beats = (span + CW'(NB - 1)) >> OFF_W;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state == RUN) && (words_left != '0) && out_free;
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign out_last   = out_valid && (beats_left == CW'(1));
  assign flush_load = (state == FLUSH) && out_free && !out_last;
  assign load       = in_hs || flush_load;

  // Tail of the current word that spills into the next beat, parked in lanes 0..off-1
  assign rem      = (OFF_W + 1)'(NB) - {1'b0, off};
  assign hold_nxt = in_data >> {rem, 3'b000};
  assign first_m  = NB'(first_strb(int'(off), NB));
  assign last_m   = NB'(last_strb(int'(e_r), NB));

  dealign_shifter #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_shift (
    .hold   (hold),
    .in_data(in_data),
    .off    (off),
    .beat   (shifted)
  );

  always_comb begin
    data_raw  = shifted;
    strb_n    = '1;
    byte_mask = '0;
    if (flush_load) begin
      data_raw = hold;
      strb_n   = last_m;
    end else begin
      if (first_pend) strb_n = strb_n & first_m;
      if ((words_left == CW'(1)) && !flush_req) strb_n = strb_n & last_m;
    end
    for (int b = 0; b < NB; b++) byte_mask[b*8 +: 8] = {8{strb_n[b]}};
    data_n = data_raw & byte_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      off        <= '0;
      e_r        <= '0;
      flush_req  <= 1'b0;
      first_pend <= 1'b0;
      words_left <= '0;
      beats_left <= '0;
      hold       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_strb   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_hs) begin
        beats_left <= beats_left - CW'(1);
        out_valid  <= 1'b0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= data_n;
        out_strb  <= strb_n;
      end
      if (in_hs) begin
        words_left <= words_left - CW'(1);
        hold       <= hold_nxt;
        first_pend <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          off        <= off_s;
          e_r        <= span[OFF_W-1:0];
          flush_req  <= out_beats > in_words;
          words_left <= in_words;
          beats_left <= out_beats;
          hold       <= '0;
          first_pend <= 1'b1;
          busy       <= 1'b1;
          state      <= (start_len == '0) ? DONE : RUN;
        end
        RUN:
          if (in_hs && (words_left == CW'(1)) && flush_req) state <= FLUSH;
          else if (out_hs && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        FLUSH:
          if (out_hs && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        DONE: begin
          // zero-length transfers arrive here still busy and report done on the way out
          state <= IDLE;
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEALIGN_ADDR_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_addr <= '0;
    else if ((state == IDLE) && start) out_addr <= {start_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    else if (out_hs) out_addr <= out_addr + ADDR_W'(NB);
  end
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^start_addr[ADDR_W-1:OFF_W];
`endif

endmodule
